approx_seq_adder: RTL and testbench

Parametrised multi-cycle approximate adder for the approximate-adder family. Each accepted operand pair is added CHUNK bits per clock, LSB chunk first, through a registered carry. The low APPROX_BITS bits are computed exact, lower-part-OR (LOA) or truncated, selected per transaction. The block sits between an operand source and a result sink, with a valid/ready handshake on each side.

---
 rtl/approx_seq_adder_pkg.sv | 20 ++
 rtl/approx_seq_adder_if.sv | 26 ++
 rtl/approx_seq_adder_chunk.sv | 37 +++
 rtl/approx_seq_adder.sv | 108 ++++++++++
 tb/tb_approx_seq_adder.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/approx_seq_adder_pkg.sv
// Shared types and constants for the sequential approximate adder family.
// Mode encodings, FSM states and the parameter sanity check live here.
package approx_adder_pkg;

  localparam logic [1:0] MODE_EXACT = 2'b00;
  localparam logic [1:0] MODE_LOA   = 2'b01;
  localparam logic [1:0] MODE_TRUNC = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit params_ok(int width, int chunk, int approx_bits);
    return (chunk > 0) && (width % chunk == 0) &&
           (approx_bits >= 0) && (approx_bits <= width);
  endfunction

endpackage

// File: rtl/approx_seq_adder_if.sv
// Operand-source and result-sink handshake bundle for approx_seq_adder.
// The slave modport is the adder's view; master is the driver/monitor view.
interface approx_seq_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output in_valid, A, B, cin, mode, out_ready,
    input  in_ready, out_valid, sum, carry
  );

  modport slave (
    input  in_valid, A, B, cin, mode, out_ready,
    output in_ready, out_valid, sum, carry
  );
endinterface

// File: rtl/approx_seq_adder_chunk.sv
// One CHUNK-bit slice of the adder, purely combinational.
// Masked bits use LOA (OR, carry = a&b) or truncation (0, no carry); others ripple.
module approx_chunk
  import approx_adder_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  input  logic [CHUNK-1:0] approx_mask,
  input  logic [1:0]       mode,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c;
  logic           loa;

  assign c[0] = cin;
  assign loa  = (mode == MODE_LOA);

  for (genvar j = 0; j < CHUNK; j++) begin : g_bit
    logic hs, hc, fs, fc;
    // full adder as two half adders; the first half-adder carry doubles as the LOA carry
    assign hs = a[j] ^ b[j];
    assign hc = a[j] & b[j];
    assign fs = hs ^ c[j];
    assign fc = hc | (hs & c[j]);

    assign s[j]   = approx_mask[j] ? (loa & (a[j] | b[j])) : fs;
    assign c[j+1] = approx_mask[j] ? (loa & hc)            : fc;
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/approx_seq_adder.sv
// Multi-cycle approximate adder: one CHUNK per clock, LSB first, registered carry.
// Latency NCHUNK cycles from accept to out_valid; result held until out_ready.
module approx_seq_adder
  import approx_adder_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int CHUNK       = 4,
  parameter int APPROX_BITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  approx_seq_adder_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!params_ok(WIDTH, CHUNK, APPROX_BITS)) begin : g_bad_params
    $error("approx_seq_adder: WIDTH must be a multiple of CHUNK and APPROX_BITS <= WIDTH");
  end

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic [1:0]        mode_q;
  logic              carry_q;

  logic              accept, last_chunk, approx_en;
  logic [CHUNK-1:0]  mask, ch_a, ch_b, ch_s;
  logic              ch_cout;

  assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));
  assign ch_a       = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign ch_b       = b_q[int'(idx_q)*CHUNK +: CHUNK];
  assign approx_en  = (mode_q == MODE_LOA) || (mode_q == MODE_TRUNC);

  // Bits below APPROX_BITS are approximate; the chunk turns the mask edge into the LOA/zero boundary carry.
  always_comb begin
    mask = '0;
    for (int j = 0; j < CHUNK; j++) begin
      mask[j] = approx_en && ((int'(idx_q) * CHUNK + j) < APPROX_BITS);
    end
  end

  approx_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a           (ch_a),
    .b           (ch_b),
    .cin         (carry_q),
    .approx_mask (mask),
    .mode        (mode_q),
    .s           (ch_s),
    .cout        (ch_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    accept        = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = rst_n;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (last_chunk) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= MODE_EXACT;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q     <= bus.A;
      b_q     <= bus.B;
      mode_q  <= bus.mode;
      carry_q <= bus.cin;
      idx_q   <= '0;
    end else if (state_q == BUSY) begin
      sum_q[int'(idx_q)*CHUNK +: CHUNK] <= ch_s;
      carry_q <= ch_cout;
      idx_q   <= idx_q + 1'b1;
    end
  end

  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;

endmodule

// File: tb/tb_approx_seq_adder.sv
// Directed bench for approx_seq_adder: default DUT (K=4) plus a K=0 instance.
module tb_approx_seq_adder;
  import approx_adder_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  approx_seq_adder_if #(.WIDTH(16)) bd ();
  approx_seq_adder_if #(.WIDTH(16)) bz ();

  approx_seq_adder #(.WIDTH(16), .CHUNK(4), .APPROX_BITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bd)
  );

  approx_seq_adder #(.WIDTH(16), .CHUNK(4), .APPROX_BITS(0)) dut_k0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offers one operand pair, then waits for out_valid; lat counts edges after the accept edge.
  task automatic run_op(input bit z, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [1:0] m,
                        output logic [15:0] s, output logic co, output int lat);
    int w;
    s   = 'x;
    co  = 1'bx;
    lat = 99;
    w   = 0;
    while (!(z ? bz.in_ready : bd.in_ready) && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (z) begin
      bz.A = a; bz.B = b; bz.cin = c; bz.mode = m; bz.in_valid = 1'b1;
    end else begin
      bd.A = a; bd.B = b; bd.cin = c; bd.mode = m; bd.in_valid = 1'b1;
    end
    @(posedge clk); #1;
    bd.in_valid = 1'b0;
    bz.in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (z ? bz.out_valid : bd.out_valid) begin
        lat = k;
        s   = z ? bz.sum : bd.sum;
        co  = z ? bz.carry : bd.carry;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bd.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", bd.in_ready); end
    total++; if (bd.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bd.out_valid); end
    total++; if (bd.sum !== 16'h0000) begin bad++; $display("FAIL reset_sum: got %h want 0000", bd.sum); end
    total++; if (bd.carry !== 1'b0) begin bad++; $display("FAIL reset_carry: got %b want 0", bd.carry); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (bd.in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b want 1", bd.in_ready); end
  endtask

  task automatic test_exact;
    logic [15:0] s; logic co; int lat;
    run_op(0, 16'h00FF, 16'h0001, 1'b0, MODE_EXACT, s, co, lat);
    total++; if (s !== 16'h0100) begin bad++; $display("FAIL exact_sum: got %h want 0100", s); end
    total++; if (co !== 1'b0) begin bad++; $display("FAIL exact_carry: got %b want 0", co); end
    total++; if (lat !== 4) begin bad++; $display("FAIL exact_latency: got %0d want 4", lat); end
  endtask

  task automatic test_loa;
    logic [15:0] s; logic co; int lat;
    run_op(0, 16'h0008, 16'h0008, 1'b0, MODE_LOA, s, co, lat);
    total++; if (s !== 16'h0018) begin bad++; $display("FAIL loa_boundary_sum: got %h want 0018", s); end
    total++; if (co !== 1'b0) begin bad++; $display("FAIL loa_boundary_carry: got %b want 0", co); end
    run_op(0, 16'h000F, 16'h0001, 1'b1, MODE_LOA, s, co, lat);
    total++; if (s !== 16'h000F) begin bad++; $display("FAIL loa_cin_ignored_sum: got %h want 000f", s); end
  endtask

  task automatic test_trunc;
    logic [15:0] s; logic co; int lat;
    run_op(0, 16'h1234, 16'h0F0F, 1'b1, MODE_TRUNC, s, co, lat);
    total++; if (s !== 16'h2130) begin bad++; $display("FAIL trunc_sum: got %h want 2130", s); end
    total++; if (co !== 1'b0) begin bad++; $display("FAIL trunc_carry: got %b want 0", co); end
    run_op(0, 16'h1234, 16'h0F0F, 1'b1, 2'b11, s, co, lat);
    total++; if (s !== 16'h2144) begin bad++; $display("FAIL mode11_sum: got %h want 2144", s); end
  endtask

  task automatic test_overflow;
    logic [15:0] s; logic co; int lat;
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, MODE_EXACT, s, co, lat);
    total++; if (s !== 16'h0000) begin bad++; $display("FAIL ovf_sum: got %h want 0000", s); end
    total++; if (co !== 1'b1) begin bad++; $display("FAIL ovf_carry: got %b want 1", co); end
    run_op(1, 16'hFFFF, 16'h0001, 1'b0, MODE_TRUNC, s, co, lat);
    total++; if (s !== 16'h0000) begin bad++; $display("FAIL k0_trunc_sum: got %h want 0000", s); end
    total++; if (co !== 1'b1) begin bad++; $display("FAIL k0_trunc_carry: got %b want 1", co); end
    total++; if (lat !== 4) begin bad++; $display("FAIL k0_latency: got %0d want 4", lat); end
  endtask

  task automatic test_backpressure;
    logic [15:0] s; logic co; int lat;
    bd.out_ready = 1'b0;
    run_op(0, 16'h1111, 16'h2222, 1'b1, MODE_EXACT, s, co, lat);
    total++; if (s !== 16'h3334) begin bad++; $display("FAIL bp_sum: got %h want 3334", s); end
    bd.A = 16'hAAAA; bd.B = 16'h0001; bd.mode = MODE_EXACT; bd.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (bd.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, bd.out_valid); end
      total++; if (bd.sum !== 16'h3334) begin bad++; $display("FAIL bp_hold_sum[%0d]: got %h want 3334", i, bd.sum); end
      total++; if (bd.carry !== 1'b0) begin bad++; $display("FAIL bp_hold_carry[%0d]: got %b want 0", i, bd.carry); end
      total++; if (bd.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bd.in_ready); end
    end
    bd.in_valid  = 1'b0;
    bd.out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (bd.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready: got %b want 1", bd.in_ready); end
    total++; if (bd.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid: got %b want 0", bd.out_valid); end
    total++; if (bd.sum !== 16'h3334) begin bad++; $display("FAIL bp_no_second_accept: got %h want 3334", bd.sum); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] s; logic co; int lat;
    bit seen;
    bd.A = 16'h1234; bd.B = 16'h0001; bd.cin = 1'b0; bd.mode = MODE_EXACT; bd.in_valid = 1'b1;
    @(posedge clk); #1;
    bd.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (bd.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid: got %b want 0", bd.out_valid); end
    total++; if (bd.sum !== 16'h0000) begin bad++; $display("FAIL mid_rst_sum: got %h want 0000", bd.sum); end
    total++; if (bd.carry !== 1'b0) begin bad++; $display("FAIL mid_rst_carry: got %b want 0", bd.carry); end
    total++; if (bd.in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_in_ready: got %b want 0", bd.in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bd.out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_rst_no_result: got %b want 0", seen); end
    total++; if (bd.in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready_after: got %b want 1", bd.in_ready); end
    run_op(0, 16'h0001, 16'h0001, 1'b0, MODE_EXACT, s, co, lat);
    total++; if (s !== 16'h0002) begin bad++; $display("FAIL mid_rst_new_sum: got %h want 0002", s); end
    total++; if (lat !== 4) begin bad++; $display("FAIL mid_rst_new_latency: got %0d want 4", lat); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bd.in_valid = 1'b0; bd.A = '0; bd.B = '0; bd.cin = 1'b0; bd.mode = MODE_EXACT; bd.out_ready = 1'b1;
    bz.in_valid = 1'b0; bz.A = '0; bz.B = '0; bz.cin = 1'b0; bz.mode = MODE_EXACT; bz.out_ready = 1'b1;
    test_reset();
    test_exact();
    test_loa();
    test_trunc();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
